// File: rtl/imm_pkg.sv
// Shared opcode constants and format/state encodings
// for the decode-stage immediate generator.
package imm_pkg;

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_e;

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate decode for one 32-bit instruction.
// Every recognised opcode ends in 2'b11, so compressed words fall to unknown.
import imm_pkg::*;

module imm_decode_comb #(
  parameter int XLEN   = 32,
  parameter bit EN_CSR = 1'b1
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            unknown
);

  logic [XLEN-1:0] sx;

  assign sx = {XLEN{inst[31]}};

  // Start from an all-sign word and overwrite the low field.
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    unknown = 1'b0;
    unique case (inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        imm       = sx;
        imm[11:0] = inst[31:20];
        fmt       = FMT_I;
      end
      OPC_OP_IMM32: begin
        if (XLEN == 64) begin
          imm       = sx;
          imm[11:0] = inst[31:20];
          fmt       = FMT_I;
        end else begin
          unknown = 1'b1;
        end
      end
      OPC_STORE: begin
        imm       = sx;
        imm[11:0] = {inst[31:25], inst[11:7]};
        fmt       = FMT_S;
      end
      OPC_BRANCH: begin
        imm       = sx;
        imm[12:0] = {inst[31], inst[7], inst[30:25],
                     inst[11:8], 1'b0};
        fmt       = FMT_B;
      end
      OPC_JAL: begin
        imm       = sx;
        imm[20:0] = {inst[31], inst[19:12], inst[20],
                     inst[30:21], 1'b0};
        fmt       = FMT_J;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm       = sx;
        imm[31:0] = {inst[31:12], 12'h000};
        fmt       = FMT_U;
      end
      OPC_SYSTEM: begin
        if (EN_CSR) begin
          imm[4:0] = inst[19:15];
          fmt      = FMT_Z;
        end else begin
          unknown = 1'b1;
        end
      end
      default: begin
        unknown = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a 2-entry skid buffer;
// in_ready depends only on the buffer state register.
import imm_pkg::*;

module imm_gen_stage #(
  parameter int XLEN   = 32,
  parameter bit EN_CSR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output fmt_e            out_fmt,
  output logic            out_unknown
);

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_unk;

  skid_e           state_q, state_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  fmt_e            out_fmt_q, out_fmt_d;
  logic            out_unk_q, out_unk_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  fmt_e            skid_fmt_q, skid_fmt_d;
  logic            skid_unk_q, skid_unk_d;
  logic            in_xfer, out_xfer;

  imm_decode_comb #(
    .XLEN   (XLEN),
    .EN_CSR (EN_CSR)
  ) u_dec (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .unknown (dec_unk)
  );

  assign in_ready    = (state_q != SKID_FULL);
  assign out_valid   = (state_q != SKID_EMPTY);
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_unknown = out_unk_q;
  assign in_xfer     = in_valid & in_ready;
  assign out_xfer    = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    out_imm_d  = out_imm_q;
    out_fmt_d  = out_fmt_q;
    out_unk_d  = out_unk_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    skid_unk_d = skid_unk_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (in_xfer) begin
          out_imm_d = dec_imm;
          out_fmt_d = dec_fmt;
          out_unk_d = dec_unk;
          state_d   = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (in_xfer && !out_xfer) begin
          skid_imm_d = dec_imm;
          skid_fmt_d = dec_fmt;
          skid_unk_d = dec_unk;
          state_d    = SKID_FULL;
        end else if (in_xfer) begin
          out_imm_d = dec_imm;
          out_fmt_d = dec_fmt;
          out_unk_d = dec_unk;
        end else if (out_xfer) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_xfer) begin
          out_imm_d = skid_imm_q;
          out_fmt_d = skid_fmt_q;
          out_unk_d = skid_unk_q;
          state_d   = SKID_ONE;
        end
      end
      default: begin
        state_d = SKID_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SKID_EMPTY;
      out_imm_q  <= '0;
      out_fmt_q  <= FMT_NONE;
      out_unk_q  <= 1'b0;
      skid_imm_q <= '0;
      skid_fmt_q <= FMT_NONE;
      skid_unk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_imm_q  <= out_imm_d;
      out_fmt_q  <= out_fmt_d;
      out_unk_q  <= out_unk_d;
      skid_imm_q <= skid_imm_d;
      skid_fmt_q <= skid_fmt_d;
      skid_unk_q <= skid_unk_d;
    end
  end

endmodule
